// File: rtl/fdsq_pkg.sv
// Shared types and constants for the FP divide/sqrt sequencer.
package fdsq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam int unsigned DIV_ITERS_DEF  = 24;
  localparam int unsigned SQRT_ITERS_DEF = 26;

  typedef logic [4:0] reg_num_t;

  // Index of the final iteration for the selected operation.
  function automatic logic [4:0] last_iter_idx(input logic sqrt,
                                               input int unsigned div_n,
                                               input int unsigned sqrt_n);
    return sqrt ? 5'(sqrt_n - 1) : 5'(div_n - 1);
  endfunction

endpackage

// File: rtl/fdsq_hazard.sv
// Compares the ID-stage source registers against the in-flight destination.
module fdsq_hazard
  import fdsq_pkg::*;
(
  input  reg_num_t fs_i,
  input  reg_num_t ft_i,
  input  logic     use_fs_i,
  input  logic     use_ft_i,
  input  reg_num_t wb_rn_i,
  output logic     hit_o
);

  reg_num_t   src [2];
  logic [1:0] use_v;
  logic [1:0] match;

  assign src[0]   = fs_i;
  assign src[1]   = ft_i;
  assign use_v[0] = use_fs_i;
  assign use_v[1] = use_ft_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cmp
      assign match[gi] = use_v[gi] && (src[gi] == wb_rn_i);
    end
  endgenerate

  assign hit_o = |match;

endmodule

// File: rtl/fdsq_ctrl.sv
// Control sequencer for the iterative FP divide / square-root unit.
// Optional FDSQ_EARLY_EXIT_EN: a zero partial remainder ends iteration early.
module fdsq_ctrl
  import fdsq_pkg::*;
#(
  parameter int unsigned DIV_ITERS  = DIV_ITERS_DEF,
  parameter int unsigned SQRT_ITERS = SQRT_ITERS_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  logic     op_sqrt,
  input  reg_num_t dst,
  input  reg_num_t fs,
  input  reg_num_t ft,
  input  logic     use_fs,
  input  logic     use_ft,
  input  logic     cancel,
  input  logic     rem_zero,
  input  logic     wb_gnt,
  output logic     busy,
  output logic     stall_div_sqrt,
  output logic     ld,
  output logic     iter_en,
  output logic [4:0] iter_cnt,
  output logic     sel_sqrt,
  output logic     wb_req,
  output reg_num_t wb_rn,
  output logic     wb_we
);

  state_e     state_q, state_d;
  logic [4:0] iter_cnt_q, iter_cnt_d;
  logic       sel_sqrt_q, sel_sqrt_d;
  reg_num_t   wb_rn_q, wb_rn_d;
  logic       accept, last_iter, early_exit, hazard_hit;

  assign accept    = (state_q == ST_IDLE) && start && !cancel;
  assign last_iter = (iter_cnt_q == last_iter_idx(sel_sqrt_q, DIV_ITERS, SQRT_ITERS));

`ifdef FDSQ_EARLY_EXIT_EN
  assign early_exit = rem_zero;
`else
  logic unused_rem_zero;
  assign early_exit      = 1'b0;
  assign unused_rem_zero = rem_zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      iter_cnt_q <= '0;
      sel_sqrt_q <= 1'b0;
      wb_rn_q    <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      sel_sqrt_q <= sel_sqrt_d;
      wb_rn_q    <= wb_rn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    sel_sqrt_d = sel_sqrt_q;
    wb_rn_d    = wb_rn_q;
    case (state_q)
      ST_IDLE: begin
        iter_cnt_d = '0;
        if (accept) begin
          state_d    = ST_LOAD;
          sel_sqrt_d = op_sqrt;
          wb_rn_d    = dst;
        end
      end
      ST_LOAD: begin
        iter_cnt_d = '0;
        state_d    = cancel ? ST_IDLE : ST_ITER;
      end
      ST_ITER: begin
        iter_cnt_d = iter_cnt_q + 5'd1;
        if (cancel)                      state_d = ST_IDLE;
        else if (last_iter || early_exit) state_d = ST_WB;
      end
      // The instruction is committed here, so cancel no longer applies.
      ST_WB: begin
        if (wb_gnt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fdsq_hazard u_hazard (
    .fs_i     (fs),
    .ft_i     (ft),
    .use_fs_i (use_fs),
    .use_ft_i (use_ft),
    .wb_rn_i  (wb_rn_q),
    .hit_o    (hazard_hit)
  );

  always_comb begin
    busy           = (state_q != ST_IDLE);
    ld             = (state_q == ST_LOAD);
    iter_en        = (state_q == ST_ITER);
    wb_req         = (state_q == ST_WB);
    wb_we          = wb_req && wb_gnt;
    stall_div_sqrt = busy && (start || hazard_hit);
  end

  assign iter_cnt = iter_cnt_q;
  assign sel_sqrt = sel_sqrt_q;
  assign wb_rn    = wb_rn_q;

endmodule

// File: tb/tb_fdsq_ctrl.sv
// Directed bench for fdsq_ctrl: write-backs are scored against an expected queue.
module tb_fdsq_ctrl;

  localparam int DIV_N  = 24;
  localparam int SQRT_N = 26;

  logic       clk, rst, start, op_sqrt, use_fs, use_ft, cancel, rem_zero, wb_gnt;
  logic [4:0] dst, fs, ft;
  logic       busy, stall_div_sqrt, ld, iter_en, sel_sqrt, wb_req, wb_we;
  logic [4:0] iter_cnt, wb_rn;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  typedef struct {
    logic [4:0] rn;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  fdsq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .op_sqrt        (op_sqrt),
    .dst            (dst),
    .fs             (fs),
    .ft             (ft),
    .use_fs         (use_fs),
    .use_ft         (use_ft),
    .cancel         (cancel),
    .rem_zero       (rem_zero),
    .wb_gnt         (wb_gnt),
    .busy           (busy),
    .stall_div_sqrt (stall_div_sqrt),
    .ld             (ld),
    .iter_en        (iter_en),
    .iter_cnt       (iter_cnt),
    .sel_sqrt       (sel_sqrt),
    .wb_req         (wb_req),
    .wb_rn          (wb_rn),
    .wb_we          (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic nc();
    @(negedge clk);
  endtask

  task automatic push(input logic [4:0] rn, input int lat);
    exp_t e;
    e.rn  = rn;
    e.cyc = cyc_n + lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      nc();
      #1;
      i++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    #1;
    if (wb_we) begin
      if (sb.size() == 0) begin
        chk("wb_we_unexpected", 32'(wb_we), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("wb_we cycle=%0d wb_rn=%0d (expected rn=%0d cycle=%0d)", cyc_n, wb_rn, e.rn, e.cyc);
        chk("wb_rn", 32'(wb_rn), 32'(e.rn));
        chk("wb_cycle", cyc_n, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_sqrt = 1'b0; dst = 5'd0; fs = 5'd0; ft = 5'd0;
    use_fs = 1'b0; use_ft = 1'b0; cancel = 1'b0; rem_zero = 1'b0; wb_gnt = 1'b1;

    // Reset state, with start presented to show it is not latched
    nc(); start = 1'b1; op_sqrt = 1'b1; dst = 5'd31; #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld", 32'(ld), 32'd0);
    chk("rst_iter_en", 32'(iter_en), 32'd0);
    chk("rst_wb_req", 32'(wb_req), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_stall", 32'(stall_div_sqrt), 32'd0);
    chk("rst_iter_cnt", 32'(iter_cnt), 32'd0);
    chk("rst_sel_sqrt", 32'(sel_sqrt), 32'd0);
    chk("rst_wb_rn", 32'(wb_rn), 32'd0);
    nc(); rst = 1'b0; start = 1'b0; op_sqrt = 1'b0; dst = 5'd0; #1;

    // Divide, dst=5, immediate grant
    $display("txn divide dst=5");
    nc(); start = 1'b1; op_sqrt = 1'b0; dst = 5'd5; push(5'd5, DIV_N + 2); #1;
    chk("div_stall_idle", 32'(stall_div_sqrt), 32'd0);
    for (int k = 1; k <= DIV_N + 2; k++) begin
      nc(); start = 1'b0; dst = 5'd0; #1;
      chk("div_ld", 32'(ld), 32'(k == 1));
      chk("div_iter_en", 32'(iter_en), 32'(k >= 2 && k <= DIV_N + 1));
      chk("div_wb_req", 32'(wb_req), 32'(k == DIV_N + 2));
      if (k >= 2 && k <= DIV_N + 1) chk("div_iter_cnt", 32'(iter_cnt), k - 2);
      if (k == 1) begin
        chk("div_wb_rn", 32'(wb_rn), 32'd5);
        chk("div_sel_sqrt", 32'(sel_sqrt), 32'd0);
      end
    end
    nc(); #1;
    chk("div_busy_done", 32'(busy), 32'd0);

    // Hazard detection against dst=7
    $display("txn hazard dst=7");
    nc(); start = 1'b1; dst = 5'd7; op_sqrt = 1'b0; push(5'd7, DIV_N + 2); #1;
    nc(); start = 1'b0; dst = 5'd0; #1;
    nc(); use_ft = 1'b1; ft = 5'd7; #1;
    chk("haz_ft_hit", 32'(stall_div_sqrt), 32'd1);
    nc(); ft = 5'd8; #1;
    chk("haz_ft_miss", 32'(stall_div_sqrt), 32'd0);
    nc(); use_ft = 1'b0; use_fs = 1'b1; fs = 5'd7; #1;
    chk("haz_fs_hit", 32'(stall_div_sqrt), 32'd1);
    nc(); use_fs = 1'b0; start = 1'b1; op_sqrt = 1'b1; dst = 5'd20; #1;
    chk("haz_start_busy", 32'(stall_div_sqrt), 32'd1);
    nc(); start = 1'b0; op_sqrt = 1'b0; dst = 5'd0; #1;
    chk("haz_no_accept_rn", 32'(wb_rn), 32'd7);
    chk("haz_no_accept_sqrt", 32'(sel_sqrt), 32'd0);
    chk("haz_clear", 32'(stall_div_sqrt), 32'd0);
    wait_idle(40);

    // Sqrt with grant withheld 3 cycles; cancel during WB is ignored
    $display("txn sqrt dst=12 delayed grant");
    nc(); wb_gnt = 1'b0; start = 1'b1; op_sqrt = 1'b1; dst = 5'd12; push(5'd12, SQRT_N + 5); #1;
    for (int k = 1; k <= SQRT_N + 1; k++) begin
      nc(); start = 1'b0; op_sqrt = 1'b0; dst = 5'd0; #1;
      chk("sqrt_no_req", 32'(wb_req), 32'd0);
      if (k == 1) chk("sqrt_sel", 32'(sel_sqrt), 32'd1);
    end
    for (int k = SQRT_N + 2; k <= SQRT_N + 4; k++) begin
      nc(); cancel = (k == SQRT_N + 3); #1;
      chk("sqrt_wait_req", 32'(wb_req), 32'd1);
      chk("sqrt_wait_we", 32'(wb_we), 32'd0);
    end
    nc(); cancel = 1'b0; wb_gnt = 1'b1; #1;
    chk("sqrt_gnt_req", 32'(wb_req), 32'd1);
    chk("sqrt_gnt_we", 32'(wb_we), 32'd1);
    nc(); #1;
    chk("sqrt_busy_done", 32'(busy), 32'd0);
    chk("sqrt_req_done", 32'(wb_req), 32'd0);

    // Cancel at iter_cnt=10, then restart immediately
    $display("txn cancel dst=9 then divide dst=3");
    nc(); start = 1'b1; dst = 5'd9; op_sqrt = 1'b0; #1;
    for (int k = 1; k <= 11; k++) begin
      nc(); start = 1'b0; dst = 5'd0; #1;
    end
    nc(); cancel = 1'b1; #1;
    chk("cxl_iter_cnt", 32'(iter_cnt), 32'd10);
    chk("cxl_iter_en", 32'(iter_en), 32'd1);
    nc(); cancel = 1'b0; start = 1'b1; dst = 5'd3; push(5'd3, DIV_N + 2); #1;
    chk("cxl_idle", 32'(busy), 32'd0);
    chk("cxl_no_req", 32'(wb_req), 32'd0);
    chk("cxl_no_stall", 32'(stall_div_sqrt), 32'd0);
    nc(); start = 1'b0; dst = 5'd0; #1;
    chk("cxl_restart_ld", 32'(ld), 32'd1);
    chk("cxl_restart_rn", 32'(wb_rn), 32'd3);
    wait_idle(40);

    // Start with cancel in IDLE is dropped
    $display("txn start+cancel in idle");
    nc(); start = 1'b1; cancel = 1'b1; dst = 5'd15; #1;
    nc(); start = 1'b0; cancel = 1'b0; dst = 5'd0; #1;
    chk("idle_cxl_busy", 32'(busy), 32'd0);
    chk("idle_cxl_ld", 32'(ld), 32'd0);

    // Back-to-back: start held through the grant cycle
    $display("txn back-to-back dst=4 then sqrt dst=6");
    nc(); start = 1'b1; dst = 5'd4; op_sqrt = 1'b0; push(5'd4, DIV_N + 2); #1;
    for (int k = 1; k <= DIV_N; k++) begin
      nc(); start = 1'b0; dst = 5'd0; #1;
    end
    nc(); start = 1'b1; op_sqrt = 1'b1; dst = 5'd6; #1;
    chk("b2b_iter_stall", 32'(stall_div_sqrt), 32'd1);
    chk("b2b_iter_en", 32'(iter_en), 32'd1);
    nc(); #1;
    chk("b2b_gnt_we", 32'(wb_we), 32'd1);
    chk("b2b_gnt_stall", 32'(stall_div_sqrt), 32'd1);
    nc(); push(5'd6, SQRT_N + 2); #1;
    chk("b2b_idle", 32'(busy), 32'd0);
    chk("b2b_idle_stall", 32'(stall_div_sqrt), 32'd0);
    nc(); start = 1'b0; op_sqrt = 1'b0; dst = 5'd0; #1;
    chk("b2b_ld", 32'(ld), 32'd1);
    chk("b2b_rn", 32'(wb_rn), 32'd6);
    chk("b2b_sqrt", 32'(sel_sqrt), 32'd1);
    wait_idle(40);

    // rem_zero at iter_cnt=3
    $display("txn rem_zero dst=10");
    nc(); start = 1'b1; dst = 5'd10; op_sqrt = 1'b0;
`ifdef FDSQ_EARLY_EXIT_EN
    push(5'd10, 6);
`else
    push(5'd10, DIV_N + 2);
`endif
    #1;
    for (int k = 1; k <= 4; k++) begin
      nc(); start = 1'b0; dst = 5'd0; #1;
    end
    nc(); rem_zero = 1'b1; #1;
    chk("rz_iter_cnt", 32'(iter_cnt), 32'd3);
    nc(); rem_zero = 1'b0; #1;
`ifdef FDSQ_EARLY_EXIT_EN
    chk("rz_early_wb", 32'(wb_req), 32'd1);
`else
    chk("rz_ignored_iter", 32'(iter_en), 32'd1);
    chk("rz_ignored_cnt", 32'(iter_cnt), 32'd4);
`endif
    wait_idle(40);

    // Asynchronous reset mid-operation: no write-back may follow
    $display("txn async reset dst=11");
    nc(); start = 1'b1; dst = 5'd11; op_sqrt = 1'b0; #1;
    repeat (5) begin
      nc(); start = 1'b0; dst = 5'd0; #1;
    end
    #2; rst = 1'b1; #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_iter_en", 32'(iter_en), 32'd0);
    chk("arst_wb_rn", 32'(wb_rn), 32'd0);
    nc(); rst = 1'b0; #1;
    repeat (30) begin
      nc(); #1;
    end
    chk("arst_stay_idle", 32'(busy), 32'd0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
